// File: rtl/tdsp_alu_pipe_if.sv
// Handshake and data bundle between operand fetch, the ALU pipe and accumulator write-back.
// The slave view belongs to the ALU. The master view belongs to the producer/consumer side.
interface tdsp_alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       cmd;
  logic             ovm;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             ovf_sticky;
  logic             clr_ovf;

  modport slave (
    input  in_valid, cmd, ovm, op_a, op_b, out_ready, clr_ovf,
    output in_ready, out_valid, result, ovf_sticky
  );

  modport master (
    output in_valid, cmd, ovm, op_a, op_b, out_ready, clr_ovf,
    input  in_ready, out_valid, result, ovf_sticky
  );
endinterface

// File: rtl/tdsp_alu_pipe.sv
// Two-stage valid/ready ALU pipe. Stage 1 holds the raw result and the overflow flag.
// Stage 2 applies saturation and holds the output, which carries a sticky overflow status.
module tdsp_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  tdsp_alu_pipe_if.slave      bus
);
  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_AND = 3'd2;
  localparam logic [2:0] CMD_OR  = 3'd3;
  localparam logic [2:0] CMD_XOR = 3'd4;
  localparam logic [2:0] CMD_ABS = 3'd5;
  localparam logic [2:0] CMD_OPA = 3'd6;

  localparam logic [WIDTH-1:0] PSAT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NSAT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_cmd_q, s1_cmd_d;
  logic             s1_ovm_q, s1_ovm_d;
  logic [WIDTH-1:0] s1_raw_q, s1_raw_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             sticky_q, sticky_d;

  logic             s2_ready, accept, advance, out_xfer;
  logic [WIDTH-1:0] sum, diff, raw, sat_val;
  logic             raw_ovf;

  assign s2_ready = !out_valid_q || bus.out_ready;
  assign advance  = s1_valid_q && s2_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  assign bus.in_ready   = !s1_valid_q || s2_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.ovf_sticky = sticky_q;

  assign sum  = bus.op_a + bus.op_b;
  assign diff = bus.op_a - bus.op_b;

  always_comb begin
    raw     = bus.op_b;
    raw_ovf = 1'b0;
    case (bus.cmd)
      CMD_ADD: begin
        raw     = sum;
        raw_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      CMD_SUB: begin
        raw     = diff;
        raw_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      CMD_AND: raw = bus.op_a & bus.op_b;
      CMD_OR:  raw = bus.op_a | bus.op_b;
      CMD_XOR: raw = bus.op_a ^ bus.op_b;
      CMD_ABS: begin
        raw     = bus.op_a[WIDTH-1] ? (~bus.op_a + ONE) : bus.op_a;
        raw_ovf = (bus.op_a == NSAT);
      end
      CMD_OPA: raw = bus.op_a;
      default: raw = bus.op_b;
    endcase
  end

  // ABS of NSAT wraps back to NSAT; its true magnitude is positive, so it clamps high.
  always_comb begin
    sat_val = s1_raw_q;
    if (s1_ovm_q && s1_ovf_q) begin
      if (s1_cmd_q == CMD_ABS) sat_val = PSAT;
      else                     sat_val = s1_raw_q[WIDTH-1] ? PSAT : NSAT;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cmd_d   = s1_cmd_q;
    s1_ovm_d   = s1_ovm_q;
    s1_raw_d   = s1_raw_q;
    s1_ovf_d   = s1_ovf_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_cmd_d   = bus.cmd;
      s1_ovm_d   = bus.ovm;
      s1_raw_d   = raw;
      s1_ovf_d   = raw_ovf;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (advance) begin
      out_valid_d = 1'b1;
      result_d    = {s1_ovf_q, sat_val};
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // A set on an ovf transfer takes priority over a clear in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (out_xfer && result_q[WIDTH]) sticky_d = 1'b1;
    else if (bus.clr_ovf)            sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_cmd_q    <= 3'd0;
      s1_ovm_q    <= 1'b0;
      s1_raw_q    <= '0;
      s1_ovf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cmd_q    <= s1_cmd_d;
      s1_ovm_q    <= s1_ovm_d;
      s1_raw_q    <= s1_raw_d;
      s1_ovf_q    <= s1_ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sticky_q    <= sticky_d;
    end
  end
endmodule

// File: tb/tb_tdsp_alu_pipe.sv
// Directed bench for tdsp_alu_pipe at WIDTH=32 and WIDTH=16.
// The expected values are worked out by hand from the operation definitions.
module tb_tdsp_alu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tdsp_alu_pipe_if #(.WIDTH(32)) bus32();
  tdsp_alu_pipe_if #(.WIDTH(16)) bus16();

  tdsp_alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  tdsp_alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  // Holds the op until it is accepted. Returns just after the accept edge.
  task automatic send32(input logic [2:0] c, input logic m, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus32.cmd = c; bus32.ovm = m; bus32.op_a = a; bus32.op_b = b; bus32.in_valid = 1'b1;
    while (!bus32.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_total++; n_bad++;
      $display("FAIL send32_timeout: in_ready stayed %b, required 1", bus32.in_ready);
    end
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
  endtask

  // Counts the falling edges after acceptance until out_valid is seen. A result of 1 means two rising edges.
  task automatic wait_out32(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!bus32.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset_idle;
    #2 reset = 1'b1;
    #1;
    n_total += 4;
    if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus32.out_valid); end
    if (bus32.result !== 33'h0) begin n_bad++; $display("FAIL rst_result: got %h want 0", bus32.result); end
    if (bus32.ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_sticky: got %b want 0", bus32.ovf_sticky); end
    if (bus32.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus32.in_ready); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_ovf;
    logic [32:0] exp [2] = '{33'h1_7FFFFFFF, 33'h1_80000000};
    int cyc;
    for (int m = 0; m < 2; m++) begin
      bus32.clr_ovf = 1'b1; @(negedge clk); bus32.clr_ovf = 1'b0;
      send32(3'd0, (m == 0), 32'h7FFFFFFF, 32'h00000001);
      wait_out32(cyc);
      n_total += 3;
      if (bus32.result !== exp[m]) begin n_bad++; $display("FAIL add_ovf_result m=%0d: got %h want %h", m, bus32.result, exp[m]); end
      if (bus32.ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL add_sticky_early m=%0d: got %b want 0", m, bus32.ovf_sticky); end
      @(negedge clk);
      if (bus32.ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL add_sticky_set m=%0d: got %b want 1", m, bus32.ovf_sticky); end
    end
  endtask

  task automatic test_reset_midflight;
    bus32.out_ready = 1'b0;
    send32(3'd0, 1'b1, 32'h7FFFFFFF, 32'h00000001);
    send32(3'd6, 1'b0, 32'h12345678, 32'h0);
    n_total++;
    if (bus32.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", bus32.in_ready); end
    #2 reset = 1'b1;
    #1;
    n_total += 4;
    if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b want 0", bus32.out_valid); end
    if (bus32.result !== 33'h0) begin n_bad++; $display("FAIL mid_rst_result: got %h want 0", bus32.result); end
    if (bus32.ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sticky: got %b want 0", bus32.ovf_sticky); end
    if (bus32.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b want 1", bus32.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ghost cyc=%0d: got %b want 0", i, bus32.out_valid); end
    end
  endtask

  task automatic test_sub_logic;
    logic [2:0]  c [2]   = '{3'd1, 3'd4};
    logic [31:0] a [2]   = '{32'h80000000, 32'hF0F0F0F0};
    logic [31:0] b [2]   = '{32'h00000001, 32'hFFFF0000};
    logic [32:0] exp [2] = '{33'h1_80000000, 33'h0_0F0FF0F0};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send32(c[i], 1'b1, a[i], b[i]);
      wait_out32(cyc);
      n_total += 2;
      if (cyc + 1 !== 2) begin n_bad++; $display("FAIL sublog_latency i=%0d: got %0d edges want 2", i, cyc + 1); end
      if (bus32.result !== exp[i]) begin n_bad++; $display("FAIL sublog_result i=%0d: got %h want %h", i, bus32.result, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_abs;
    logic        m [3]   = '{1'b1, 1'b0, 1'b1};
    logic [31:0] a [3]   = '{32'h80000000, 32'h80000000, 32'hFFFFFFFB};
    logic [32:0] exp [3] = '{33'h1_7FFFFFFF, 33'h1_80000000, 33'h0_00000005};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      send32(3'd5, m[i], a[i], 32'hDEADBEEF);
      wait_out32(cyc);
      n_total++;
      if (bus32.result !== exp[i]) begin n_bad++; $display("FAIL abs_result i=%0d: got %h want %h", i, bus32.result, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [2:0]  c [6]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [31:0] a [6]   = '{32'h1, 32'h5, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h12345678, 32'h0};
    logic [31:0] b [6]   = '{32'h2, 32'h7, 32'hFFFF0000, 32'h10000000, 32'h0, 32'hCAFEBABE};
    logic [32:0] exp [6] = '{33'h0_00000003, 33'h0_FFFFFFFE, 33'h0_F0F00000, 33'h0_1F0F0F0F, 33'h0_12345678, 33'h0_CAFEBABE};
    logic [15:0] rdy_pat = 16'b0110_0101_1100_1010;
    int sent = 0, got = 0, cyc = 0, s1_items;
    logic stalled = 1'b0, exp_in_ready;
    logic [32:0] held = '0;
    while (got < 6 && cyc < 100) begin
      if (stalled) begin
        n_total += 2;
        if (bus32.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc=%0d: got %b want 1", cyc, bus32.out_valid); end
        if (bus32.result !== held) begin n_bad++; $display("FAIL bp_hold_result cyc=%0d: got %h want %h", cyc, bus32.result, held); end
      end
      bus32.out_ready = rdy_pat[cyc % 16];
      bus32.in_valid  = (sent < 6);
      if (sent < 6) begin
        bus32.cmd = c[sent]; bus32.op_a = a[sent]; bus32.op_b = b[sent]; bus32.ovm = 1'b1;
      end
      #1;
      s1_items = sent - got - (bus32.out_valid ? 1 : 0);
      exp_in_ready = (s1_items == 0) || !bus32.out_valid || bus32.out_ready;
      n_total++;
      if (bus32.in_ready !== exp_in_ready) begin n_bad++; $display("FAIL bp_in_ready cyc=%0d: got %b want %b", cyc, bus32.in_ready, exp_in_ready); end
      if (bus32.out_valid && bus32.out_ready) begin
        n_total++;
        if (bus32.result !== exp[got]) begin n_bad++; $display("FAIL bp_order k=%0d: got %h want %h", got, bus32.result, exp[got]); end
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) sent++;
      stalled = bus32.out_valid && !bus32.out_ready;
      held = bus32.result;
      @(negedge clk);
      cyc++;
    end
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    n_total++;
    if (got !== 6) begin n_bad++; $display("FAIL bp_count: got %0d results want 6", got); end
    @(negedge clk);
  endtask

  task automatic test_sticky_priority;
    int cyc = 0;
    bus32.clr_ovf = 1'b1; @(negedge clk); bus32.clr_ovf = 1'b0;
    bus32.out_ready = 1'b0;
    send32(3'd0, 1'b1, 32'h7FFFFFFF, 32'h00000001);
    @(negedge clk);
    while (!bus32.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    n_total += 4;
    if (bus32.result !== 33'h1_7FFFFFFF) begin n_bad++; $display("FAIL sticky_result: got %h want 17fffffff", bus32.result); end
    bus32.out_ready = 1'b1;
    bus32.clr_ovf = 1'b1;
    @(negedge clk);
    if (bus32.ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set_wins: got %b want 1", bus32.ovf_sticky); end
    if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL sticky_drained: got %b want 0", bus32.out_valid); end
    @(negedge clk);
    bus32.clr_ovf = 1'b0;
    if (bus32.ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b want 0", bus32.ovf_sticky); end
  endtask

  task automatic test_width16;
    int cyc = 0;
    bus16.clr_ovf = 1'b1; @(negedge clk); bus16.clr_ovf = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.cmd = 3'd0; bus16.ovm = 1'b1; bus16.op_a = 16'h7FFF; bus16.op_b = 16'h0001;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    @(negedge clk);
    while (!bus16.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    n_total += 4;
    if (bus16.result !== 17'h1_7FFF) begin n_bad++; $display("FAIL w16_result: got %h want 17fff", bus16.result); end
    bus16.out_ready = 1'b1;
    bus16.clr_ovf = 1'b1;
    @(negedge clk);
    if (bus16.ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL w16_set_wins: got %b want 1", bus16.ovf_sticky); end
    if (bus16.out_valid !== 1'b0) begin n_bad++; $display("FAIL w16_drained: got %b want 0", bus16.out_valid); end
    @(negedge clk);
    bus16.clr_ovf = 1'b0;
    if (bus16.ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL w16_clear: got %b want 0", bus16.ovf_sticky); end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.cmd = 3'd0; bus32.ovm = 1'b0; bus32.op_a = '0; bus32.op_b = '0;
    bus32.out_ready = 1'b1; bus32.clr_ovf = 1'b0;
    bus16.in_valid = 1'b0; bus16.cmd = 3'd0; bus16.ovm = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
    bus16.out_ready = 1'b1; bus16.clr_ovf = 1'b0;
    test_reset_idle();
    test_add_ovf();
    test_reset_midflight();
    test_sub_logic();
    test_abs();
    test_backpressure();
    test_sticky_priority();
    test_width16();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
